mem_region_controller: RTL and testbench
========================================

Name: mem_region_controller

Overview:
Parametrised successor to the core's memory interface. Decodes a CPU bus request into one of NUM_REGIONS address windows (boot/text/data/ktext/kdata by default) and drives the selected synchronous RAM/ROM. A request/ready FSM covers configurable RAM read latency, issues exactly one write-strobe cycle per write, enforces per-region write protection and returns 0 (not Z) for unmapped accesses. Sits between the MIPS core bus and the on-chip altsyncram blocks.

Parameters:
NUM_REGIONS, 5, number of address windows; index 0 = highest decode priority
READ_LATENCY, 1, RAM clock-to-q cycles (legal 1..3)
REGION_BASE, {0x90000000,0x80000000,0x10010000,0x00400000,0x00000000}, packed NUM_REGIONS*32, inclusive byte base per region (region 0 in LSBs)
REGION_LIMIT, {0x900007FF,0x80001FFF,0x10011FFF,0x00403FFF,0x000001FF}, packed NUM_REGIONS*32, inclusive byte limit
REGION_WRITABLE, 5'b11110, bit i=1 allows writes to region i (region 0 boot ROM read-only)

Ports:
iCLK  in  1  single system clock; all logic on rising edge
iRST  in  1  synchronous, active-high reset
iReadEnable  in  1  read request; held until oReady
iWriteEnable  in  1  write request; held until oReady; priority over read
iByteEnable  in  4  write byte lanes
iAddress  in  32  byte address
iWriteData  in  32  write data
oReadData  out  32  read data, valid when oReady
oReady  out  1  one-cycle completion pulse
oBusy  out  1  high while FSM not IDLE
oMemSel  out  NUM_REGIONS  one-hot region select (registered)
oMemWren  out  NUM_REGIONS  one-hot write strobe, one cycle per write
oMemAddress  out  30  word offset (iAddress - base) >> 2
oMemByteEnable  out  4  registered copy of iByteEnable
oMemWriteData  out  32  registered copy of iWriteData
iMemReadData  in  NUM_REGIONS*32  per-region RAM q, region i at [32i+31:32i]
oFault  out  1  access fault indicator (see Optional Feature)
oFaultAddress  out  32  first faulting address (see Optional Feature)

Behaviour:
- Reset: FSM=IDLE; oReadData, oMemSel, oMemWren, oMemAddress, oMemByteEnable, oMemWriteData, oFaultAddress=0; oReady=oBusy=oFault=0.
- Decode: hit_i = BASE_i <= iAddress <= LIMIT_i, unsigned, full 32 bits; lowest-index hit wins on overlap. Fault = no hit, or write to region with WRITABLE bit 0.
- States IDLE, ACCESS, WAIT, RESP. Request sampled only in IDLE.
- IDLE: if iWriteEnable|iReadEnable -> ACCESS; latch select, offset, byte enables, write data, op (write if iWriteEnable, including when both asserted).
- ACCESS (1 cycle): oMemSel one-hot (all 0 on fault). Write, no fault: oMemWren[i]=1 for this cycle only, then -> RESP. Read, no fault: -> WAIT. Fault: no strobe, -> RESP.
- WAIT: counts READ_LATENCY cycles; on last cycle captures iMemReadData slice of selected region into oReadData; -> RESP.
- RESP: oReady=1 for one cycle, -> IDLE. Faulted read gives oReadData=0. oReadData holds its value until the next read completes.
- Latency request->oReady: write 2 cycles; read 2+READ_LATENCY (3 at default). Back-to-back: next request accepted at earliest the cycle after oReady.
- Requests arriving outside IDLE are ignored (not queued).
- iRST in any state: next edge returns to IDLE; oMemWren is gated by ~iRST, so a write in ACCESS during reset is never issued; a pending oReady is dropped.
- oBusy = (state != IDLE).

Optional Feature:
MEM_REGION_FAULT_EN. Defined: oFault is sticky, set in the RESP of a faulted access and cleared only by iRST; oFaultAddress latches iAddress of the first fault only. Undefined: oFault=0 and oFaultAddress=0 constantly; faults still suppress strobes and return 0.

Test Plan:
- Read 0x00400004, READ_LATENCY=1, text RAM q=0xDEADBEEF -> oMemSel=5'b00010, oMemAddress=1; oReady on cycle 3 with oReadData=0xDEADBEEF.
- Write 0x10010008, data 0x12345678, byte-enable 4'b0011 -> oMemWren=5'b00100 for exactly one cycle, oMemAddress=2, oMemByteEnable=4'b0011; oReady on cycle 2.
- Write 0x00000010 (boot ROM) -> oMemWren stays 0; oReady on cycle 2; with MEM_REGION_FAULT_EN, oFault=1 and oFaultAddress=0x00000010.
- Read 0x20000000 (unmapped) then read 0x80000000 -> first returns 0; oFaultAddress stays 0x20000000 after a second fault; ktext read completes normally.
- iReadEnable and iWriteEnable both high at 0x90000000 -> write executed (oMemWren=5'b10000), no RAM read captured.
- iRST asserted during ACCESS of a write to 0x10010000 -> no oMemWren pulse, no oReady; FSM in IDLE and oBusy=0 on the next cycle.

Source files
------------

// File: rtl/mem_region_controller.sv
// mem_region_controller
// Decodes a CPU bus request into one of NUM_REGIONS address windows and
// drives the selected synchronous RAM/ROM through a small request/ready FSM.
// Optional build macro: MEM_REGION_FAULT_EN. When defined, oFault is a sticky
// fault flag and oFaultAddress holds the first faulting address. When it is
// undefined, both outputs are tied to zero.
//
// Handshake: the requester raises iReadEnable or iWriteEnable and holds it
// (with stable address/data) until oReady. oReady is a single-cycle
// completion pulse. A request is sampled only while the FSM is IDLE.
// Requests that arrive while the FSM is busy are ignored, not queued.
module mem_region_controller #(
  parameter int                        NUM_REGIONS     = 5,
  parameter int                        READ_LATENCY    = 1,
  parameter logic [NUM_REGIONS*32-1:0] REGION_BASE     = {32'h9000_0000, 32'h8000_0000,
                                                          32'h1001_0000, 32'h0040_0000,
                                                          32'h0000_0000},
  parameter logic [NUM_REGIONS*32-1:0] REGION_LIMIT    = {32'h9000_07FF, 32'h8000_1FFF,
                                                          32'h1001_1FFF, 32'h0040_3FFF,
                                                          32'h0000_01FF},
  parameter logic [NUM_REGIONS-1:0]    REGION_WRITABLE = 5'b11110
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iReadEnable,
  input  logic                      iWriteEnable,
  input  logic [3:0]                iByteEnable,
  input  logic [31:0]               iAddress,
  input  logic [31:0]               iWriteData,
  output logic [31:0]               oReadData,
  output logic                      oReady,
  output logic                      oBusy,
  output logic [NUM_REGIONS-1:0]    oMemSel,
  output logic [NUM_REGIONS-1:0]    oMemWren,
  output logic [29:0]               oMemAddress,
  output logic [3:0]                oMemByteEnable,
  output logic [31:0]               oMemWriteData,
  input  logic [NUM_REGIONS*32-1:0] iMemReadData,
  output logic                      oFault,
  output logic [31:0]               oFaultAddress,
  output logic [1:0]                oDbgState
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);

  state_t                 r_state;
  logic [NUM_REGIONS-1:0] r_sel;
  logic [NUM_REGIONS-1:0] r_wren;
  logic [29:0]            r_offset;
  logic [3:0]             r_be;
  logic [31:0]            r_wdata;
  logic                   r_is_write;
  logic                   r_flt;
  logic [1:0]             r_cnt;
  logic [31:0]            r_rdata;
  logic                   r_ready;

  logic                   w_hit;
  logic [NUM_REGIONS-1:0] w_sel;
  logic [29:0]            w_offset;
  logic                   w_fault;
  logic [31:0]            w_q;

  // Address decode: scan from the highest index down so the lowest-index hit wins.
  always_comb begin
    w_hit    = 1'b0;
    w_sel    = '0;
    w_offset = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((iAddress >= REGION_BASE[32*i +: 32]) && (iAddress <= REGION_LIMIT[32*i +: 32])) begin
        w_hit    = 1'b1;
        w_sel    = NUM_REGIONS'(1) << i;
        w_offset = 30'((iAddress - REGION_BASE[32*i +: 32]) >> 2);
      end
    end
    // Unmapped, or a write into a region whose protection bit is clear.
    w_fault = ~w_hit | (iWriteEnable & ~(|(w_sel & REGION_WRITABLE)));
  end

  // Read-data mux: pick the q slice of the latched region.
  always_comb begin
    w_q = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (r_sel[i]) w_q = iMemReadData[32*i +: 32];
    end
  end

  // Main request/ready FSM with registered outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_wren     <= '0;
      r_offset   <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_flt      <= 1'b0;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_wren  <= '0;
      case (r_state)
        S_IDLE: begin
          if (iWriteEnable || iReadEnable) begin
            r_state    <= S_ACCESS;
            r_sel      <= w_fault ? '0 : w_sel;
            r_wren     <= (iWriteEnable && !w_fault) ? w_sel : '0;
            r_offset   <= w_offset;
            r_be       <= iByteEnable;
            r_wdata    <= iWriteData;
            r_is_write <= iWriteEnable;
            r_flt      <= w_fault;
          end
        end
        S_ACCESS: begin
          if (r_flt || r_is_write) begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
            r_sel   <= '0;
            // A faulted read completes with zero data, never a stale value.
            if (r_flt && !r_is_write) r_rdata <= '0;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (r_cnt == LAST_WAIT) begin
            r_rdata <= w_q;
            r_state <= S_RESP;
            r_ready <= 1'b1;
            r_sel   <= '0;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_REGION_FAULT_EN
  logic        r_fault;
  logic [31:0] r_fault_addr;
  logic [31:0] r_req_addr;

  // Sticky fault flag: it rises with the oReady of the first faulted access.
  // It is cleared only by reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
      r_req_addr   <= '0;
    end else begin
      if (r_state == S_IDLE && (iWriteEnable || iReadEnable)) r_req_addr <= iAddress;
      if (r_state == S_ACCESS && r_flt && !r_fault) begin
        r_fault      <= 1'b1;
        r_fault_addr <= r_req_addr;
      end
    end
  end

  assign oFault        = r_fault;
  assign oFaultAddress = r_fault_addr;
`else
  assign oFault        = 1'b0;
  assign oFaultAddress = '0;
`endif

  // The write strobe is masked by reset so a write caught in ACCESS is never issued.
  assign oMemWren       = r_wren & {NUM_REGIONS{~iRST}};
  assign oMemSel        = r_sel;
  assign oMemAddress    = r_offset;
  assign oMemByteEnable = r_be;
  assign oMemWriteData  = r_wdata;
  assign oReadData      = r_rdata;
  assign oReady         = r_ready;
  assign oBusy          = (r_state != S_IDLE);
  assign oDbgState      = r_state;

endmodule

// File: tb/tb_mem_region_controller.sv
// Directed bench for mem_region_controller with a response scoreboard.
module tb_mem_region_controller;

`ifdef MEM_REGION_FAULT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  // clock / reset
  logic iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  logic         iRST = 1'b1;
  logic         iReadEnable = 1'b0;
  logic         iWriteEnable = 1'b0;
  logic [3:0]   iByteEnable = '0;
  logic [31:0]  iAddress = '0;
  logic [31:0]  iWriteData = '0;
  logic [159:0] iMemReadData;
  logic [31:0]  oReadData;
  logic         oReady;
  logic         oBusy;
  logic [4:0]   oMemSel;
  logic [4:0]   oMemWren;
  logic [29:0]  oMemAddress;
  logic [3:0]   oMemByteEnable;
  logic [31:0]  oMemWriteData;
  logic         oFault;
  logic [31:0]  oFaultAddress;
  logic [1:0]   oDbgState;

  mem_region_controller dut (
    .iCLK(iCLK), .iRST(iRST),
    .iReadEnable(iReadEnable), .iWriteEnable(iWriteEnable),
    .iByteEnable(iByteEnable), .iAddress(iAddress), .iWriteData(iWriteData),
    .oReadData(oReadData), .oReady(oReady), .oBusy(oBusy),
    .oMemSel(oMemSel), .oMemWren(oMemWren), .oMemAddress(oMemAddress),
    .oMemByteEnable(oMemByteEnable), .oMemWriteData(oMemWriteData),
    .iMemReadData(iMemReadData), .oFault(oFault), .oFaultAddress(oFaultAddress),
    .oDbgState(oDbgState)
  );

  int total = 0;
  int bad = 0;
  logic [64:0] exp_q[$];   // {fault, fault_addr, read_data}
  logic [64:0] exp_e;
  int          wren_pulses = 0;
  logic [4:0]  wren_seen = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // scoreboard monitor: strobe tracking and response compare
  always @(negedge iCLK) begin
    if (|oMemWren) begin
      wren_pulses++;
      wren_seen = oMemWren;
    end
    if (oReady) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got oReady=1 expected no response");
      end else begin
        exp_e = exp_q.pop_front();
        chk("rdata", oReadData, exp_e[31:0]);
        chk("fault", oFault, exp_e[64]);
        chk("fault_addr", oFaultAddress, exp_e[63:32]);
      end
    end
  end

  // driver: one request, hand-computed expectations
  task automatic do_req(input string tag, input logic rd, input logic wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input int exp_lat,
                        input logic [4:0] exp_sel, input logic [4:0] exp_wren,
                        input logic chk_maddr, input logic [29:0] exp_maddr,
                        input logic exp_f, input logic [31:0] exp_fa);
    int lat;
    lat = 0;
    @(posedge iCLK); #1;
    wren_pulses = 0;
    wren_seen   = '0;
    exp_q.push_back({FEN ? exp_f : 1'b0, FEN ? exp_fa : 32'h0, exp_rd});
    iReadEnable  = rd;
    iWriteEnable = wr;
    iByteEnable  = be;
    iAddress     = addr;
    iWriteData   = wdata;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge iCLK);
      @(negedge iCLK);
      if (n == 1) begin
        chk({tag, "_sel"}, oMemSel, exp_sel);
        chk({tag, "_be"}, oMemByteEnable, be);
        chk({tag, "_wdata"}, oMemWriteData, wdata);
        if (chk_maddr) chk({tag, "_maddr"}, oMemAddress, exp_maddr);
      end
      if (oReady) lat = n;
    end
    if (lat == 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no oReady in 20 cycles expected %0d", tag, exp_lat);
    end else begin
      chk({tag, "_latency"}, lat, exp_lat);
    end
    iReadEnable  = 1'b0;
    iWriteEnable = 1'b0;
    chk({tag, "_wren_pulses"}, wren_pulses, (exp_wren != 0) ? 1 : 0);
    chk({tag, "_wren"}, wren_seen, exp_wren);
  endtask

  task automatic do_reset();
    @(posedge iCLK); #1;
    iRST = 1'b1;
    @(posedge iCLK);
    @(posedge iCLK); #1;
    iRST = 1'b0;
  endtask

  initial begin
    iMemReadData = {32'h55AA1234, 32'hCAFEF00D, 32'h0DA7A222, 32'hDEADBEEF, 32'hB0075EED};

    // reset state
    repeat (3) @(posedge iCLK);
    #1 iRST = 1'b0;
    @(negedge iCLK);
    chk("rst_rdata", oReadData, 32'h0);
    chk("rst_ready", oReady, 1'b0);
    chk("rst_busy", oBusy, 1'b0);
    chk("rst_sel", oMemSel, 5'b0);
    chk("rst_wren", oMemWren, 5'b0);
    chk("rst_maddr", oMemAddress, 30'h0);
    chk("rst_be", oMemByteEnable, 4'h0);
    chk("rst_wdata", oMemWriteData, 32'h0);
    chk("rst_fault", oFault, 1'b0);
    chk("rst_faddr", oFaultAddress, 32'h0);
    chk("rst_state", oDbgState, 2'd0);

    do_req("rd_text", 1, 0, 4'h0, 32'h0040_0004, 32'h0, 32'hDEADBEEF, 3, 5'b00010, 5'b0, 1, 30'd1, 0, 32'h0);
    do_req("wr_data", 0, 1, 4'b0011, 32'h1001_0008, 32'h12345678, 32'hDEADBEEF, 2, 5'b00100, 5'b00100, 1, 30'd2, 0, 32'h0);
    do_req("wr_boot", 0, 1, 4'hF, 32'h0000_0010, 32'hFFFF0000, 32'hDEADBEEF, 2, 5'b0, 5'b0, 0, 30'd0, 1, 32'h10);

    do_reset();
    @(negedge iCLK);
    chk("rst2_fault", oFault, 1'b0);
    chk("rst2_rdata", oReadData, 32'h0);

    do_req("rd_unmapped", 1, 0, 4'h0, 32'h2000_0000, 32'h0, 32'h0, 2, 5'b0, 5'b0, 0, 30'd0, 1, 32'h2000_0000);
    do_req("rd_ktext", 1, 0, 4'h0, 32'h8000_0000, 32'h0, 32'hCAFEF00D, 3, 5'b01000, 5'b0, 1, 30'd0, 1, 32'h2000_0000);
    do_req("wr_boot2", 0, 1, 4'hF, 32'h0000_0004, 32'h1, 32'hCAFEF00D, 2, 5'b0, 5'b0, 0, 30'd0, 1, 32'h2000_0000);
    do_req("rd_boot_lim", 1, 0, 4'h0, 32'h0000_01FC, 32'h0, 32'hB0075EED, 3, 5'b00001, 5'b0, 1, 30'h7F, 1, 32'h2000_0000);
    do_req("rd_past_boot", 1, 0, 4'h0, 32'h0000_0200, 32'h0, 32'h0, 2, 5'b0, 5'b0, 0, 30'd0, 1, 32'h2000_0000);
    do_req("rd_kdata", 1, 0, 4'h0, 32'h9000_0004, 32'h0, 32'h55AA1234, 3, 5'b10000, 5'b0, 1, 30'd1, 1, 32'h2000_0000);
    // new kdata q: a wrongly captured read would overwrite the held value
    iMemReadData[159:128] = 32'h99999999;
    do_req("rd_wr_both", 1, 1, 4'hF, 32'h9000_0000, 32'hA5A5A5A5, 32'h55AA1234, 2, 5'b10000, 5'b10000, 1, 30'd0, 1, 32'h2000_0000);

    // reset while a write sits in ACCESS
    @(posedge iCLK); #1;
    wren_pulses = 0;
    iWriteEnable = 1'b1;
    iByteEnable  = 4'hF;
    iAddress     = 32'h1001_0000;
    iWriteData   = 32'h0BADF00D;
    @(posedge iCLK); #1;
    iRST = 1'b1;
    @(negedge iCLK);
    chk("rstw_busy_access", oBusy, 1'b1);
    chk("rstw_wren_gated", oMemWren, 5'b0);
    @(posedge iCLK); #1;
    iRST = 1'b0;
    iWriteEnable = 1'b0;
    @(negedge iCLK);
    chk("rstw_busy", oBusy, 1'b0);
    chk("rstw_ready", oReady, 1'b0);
    chk("rstw_state", oDbgState, 2'd0);
    repeat (4) @(posedge iCLK);
    @(negedge iCLK);
    chk("rstw_no_strobe", wren_pulses, 0);
    chk("rstw_fault", oFault, 1'b0);

    do_req("rd_data_lim", 1, 0, 4'h0, 32'h1001_1FFC, 32'h0, 32'h0DA7A222, 3, 5'b00100, 5'b0, 1, 30'h7FF, 0, 32'h0);

    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
